// File: rtl/pipe_pkg.sv
// Shared definitions for the A/B accumulator pipeline controller:
// opcode encodings, controller state, and opcode class helpers.
package pipe_pkg;

  localparam int OP_W = 6;
  typedef logic [OP_W-1:0] op_t;

  // Instruction-set opcode encodings (instr[15:10])
  localparam op_t OP_NOP  = 6'd0;
  localparam op_t OP_LDA  = 6'd1;
  localparam op_t OP_LDB  = 6'd2;
  localparam op_t OP_STA  = 6'd3;
  localparam op_t OP_STB  = 6'd4;
  localparam op_t OP_LDCA = 6'd5;
  localparam op_t OP_LDCB = 6'd6;
  localparam op_t OP_ADDA = 6'd7;
  localparam op_t OP_ADDB = 6'd8;
  localparam op_t OP_SUBA = 6'd9;
  localparam op_t OP_SUBB = 6'd10;
  localparam op_t OP_ANDA = 6'd11;
  localparam op_t OP_ANDB = 6'd12;
  localparam op_t OP_ORA  = 6'd13;
  localparam op_t OP_ORB  = 6'd14;
  localparam op_t OP_ASLA = 6'd15;
  localparam op_t OP_ASRA = 6'd16;
  localparam op_t OP_ASLB = 6'd17;
  localparam op_t OP_ASRB = 6'd18;
  localparam op_t OP_JMP  = 6'd19;
  localparam op_t OP_BAEQ = 6'd20;
  localparam op_t OP_BAGT = 6'd21;
  localparam op_t OP_BALT = 6'd22;
  localparam op_t OP_BAPL = 6'd23;
  localparam op_t OP_BBEQ = 6'd24;
  localparam op_t OP_BBGT = 6'd25;
  localparam op_t OP_BBLT = 6'd26;
  localparam op_t OP_BBPL = 6'd27;

  typedef enum logic [1:0] {
    S_FILL     = 2'd0,
    S_RUN      = 2'd1,
    S_WAIT_MEM = 2'd2,
    S_ERR      = 2'd3
  } state_t;

  function automatic logic isMem(input op_t op);
    return (op == OP_LDA) || (op == OP_LDB) || (op == OP_STA) || (op == OP_STB);
  endfunction

  function automatic logic isLoadAcc(input op_t op);
    return (op == OP_LDA) || (op == OP_LDB);
  endfunction

  // JMP and the contiguous conditional-branch block BAEQ..BBPL
  function automatic logic isBranch(input op_t op);
    return (op == OP_JMP) || ((op >= OP_BAEQ) && (op <= OP_BBPL));
  endfunction

  // Two-operand ALU ops combine A and B, so they appear in both read sets
  function automatic logic readsA(input op_t op);
    case (op)
      OP_STA, OP_ADDA, OP_ADDB, OP_SUBA, OP_SUBB, OP_ANDA, OP_ANDB,
      OP_ORA, OP_ORB, OP_ASLA, OP_ASRA,
      OP_BAEQ, OP_BAGT, OP_BALT, OP_BAPL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic readsB(input op_t op);
    case (op)
      OP_STB, OP_ADDA, OP_ADDB, OP_SUBA, OP_SUBB, OP_ANDA, OP_ANDB,
      OP_ORA, OP_ORB, OP_ASLB, OP_ASRB,
      OP_BBEQ, OP_BBGT, OP_BBLT, OP_BBPL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Among the loads, LDB is the one targeting B; LDA targets A
  function automatic logic writesAccB(input op_t op);
    return (op == OP_LDB);
  endfunction

endpackage

// File: rtl/pipe_ctrl_op_class.sv
// Combinational opcode-to-class decode, one instance per pipeline stage.
module op_class
  import pipe_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] op,
  output logic           is_mem,
  output logic           is_load_acc,
  output logic           is_branch,
  output logic           is_jmp,
  output logic           reads_a,
  output logic           reads_b,
  output logic           writes_b
);

  op_t op_n;

  // Normalise to the package opcode width, then classify
  always_comb begin
    op_n        = op_t'(op);
    is_mem      = isMem(op_n);
    is_load_acc = isLoadAcc(op_n);
    is_branch   = isBranch(op_n);
    is_jmp      = (op_n == OP_JMP);
    reads_a     = readsA(op_n);
    reads_b     = readsB(op_n);
    writes_b    = writesAccB(op_n);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stage enables, flush/bubble, PC select
// and data-memory request handshake for the A/B accumulator pipeline.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int OPW         = 6,
  parameter int FILL_CYCLES = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] idOp,
  input  logic           idValid,
  input  logic [OPW-1:0] exOp,
  input  logic           exValid,
  input  logic           exCondMet,
  input  logic           memAck,
  output logic           pcEn,
  output logic           ifIdEn,
  output logic           idExEn,
  output logic           exMemEn,
  output logic           ifIdFlush,
  output logic           idExBubble,
  output logic           pcSelBranch,
  output logic           memReq,
  output logic           errFlag
);

  localparam int FW = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;

  state_t        state_q, state_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [3:0]    wait_q, wait_d;
  logic          err_q, err_d;

  logic id_mem, id_ld, id_br, id_jmp, id_ra, id_rb, id_wb;
  logic ex_mem, ex_ld, ex_br, ex_jmp, ex_ra, ex_rb, ex_wb;
  logic br_taken, mem_op, hazard;

  op_class #(.OPW(OPW)) u_id_class (
    .op(idOp), .is_mem(id_mem), .is_load_acc(id_ld), .is_branch(id_br),
    .is_jmp(id_jmp), .reads_a(id_ra), .reads_b(id_rb), .writes_b(id_wb)
  );

  op_class #(.OPW(OPW)) u_ex_class (
    .op(exOp), .is_mem(ex_mem), .is_load_acc(ex_ld), .is_branch(ex_br),
    .is_jmp(ex_jmp), .reads_a(ex_ra), .reads_b(ex_rb), .writes_b(ex_wb)
  );

  // RUN-decision terms, shared by RUN and the WAIT_MEM ack cycle
  always_comb begin
    br_taken = exValid && ex_br && (ex_jmp || exCondMet);
    mem_op   = exValid && ex_mem;
    hazard   = exValid && idValid && ex_ld &&
               (ex_wb ? id_rb : id_ra);
  end

  // State, fill counter, wait counter and sticky error register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FILL;
      fill_q  <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Next state and combinational outputs; reset forces the reset values
  // directly so memReq drops without waiting for an edge.
  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    wait_d      = wait_q;
    err_d       = err_q;
    pcEn        = 1'b1;
    ifIdEn      = 1'b1;
    idExEn      = 1'b1;
    exMemEn     = 1'b1;
    ifIdFlush   = 1'b0;
    idExBubble  = 1'b0;
    pcSelBranch = 1'b0;
    memReq      = 1'b0;

    case (state_q)
      S_FILL: begin
        idExBubble = 1'b1;
        if (fill_q == FW'(FILL_CYCLES - 1)) begin
          state_d = S_RUN;
          fill_d  = '0;
        end else begin
          fill_d = fill_q + 1'b1;
        end
      end

      S_RUN: begin
        if (br_taken) begin
          pcSelBranch = 1'b1;
          ifIdFlush   = 1'b1;
          idExBubble  = 1'b1;
        end else if (mem_op && !memAck) begin
          // Miss: freeze everything; this cycle counts as request cycle 1
          memReq  = 1'b1;
          pcEn    = 1'b0;
          ifIdEn  = 1'b0;
          idExEn  = 1'b0;
          exMemEn = 1'b0;
          state_d = S_WAIT_MEM;
          wait_d  = 4'd1;
        end else begin
          memReq = mem_op;
          if (hazard) begin
            pcEn       = 1'b0;
            ifIdEn     = 1'b0;
            idExBubble = 1'b1;
          end
        end
      end

      S_WAIT_MEM: begin
        memReq = 1'b1;
        if (!memAck) begin
          pcEn    = 1'b0;
          ifIdEn  = 1'b0;
          idExEn  = 1'b0;
          exMemEn = 1'b0;
          wait_d  = (wait_q == 4'hF) ? wait_q : wait_q + 1'b1;
          if (wait_q == 4'(MEM_TIMEOUT)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end else begin
          // Ack completes the access; a load-use hazard still applies
          state_d = S_RUN;
          wait_d  = '0;
          if (hazard) begin
            pcEn       = 1'b0;
            ifIdEn     = 1'b0;
            idExBubble = 1'b1;
          end
        end
      end

      default: begin // S_ERR: held until reset
        pcEn       = 1'b0;
        ifIdEn     = 1'b0;
        idExEn     = 1'b0;
        exMemEn    = 1'b0;
        ifIdFlush  = 1'b1;
        idExBubble = 1'b1;
      end
    endcase

    if (reset) begin
      pcEn        = 1'b0;
      ifIdEn      = 1'b0;
      idExEn      = 1'b0;
      exMemEn     = 1'b0;
      ifIdFlush   = 1'b1;
      idExBubble  = 1'b1;
      pcSelBranch = 1'b0;
      memReq      = 1'b0;
    end
  end

  // Sticky flag is the registered copy, cleared by reset
  always_comb errFlag = err_q;

endmodule
